// File: rtl/mult_div_if.sv
// Operand/command and HI/LO result bundle between the execute stage and the
// iterative multiply/divide unit.
interface mult_div_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             we_hi;
    logic             we_lo;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic [1:0]       dbg_state;

    // start is a single-cycle command taken only while busy is low; done
    // pulses for exactly one cycle once hi/lo carry the completed result.
    modport master (
        output start, op, srcA, srcB, we_hi, we_lo, wdata,
        input  hi, lo, busy, done, dbg_state
    );

    modport slave (
        input  start, op, srcA, srcB, we_hi, we_lo, wdata,
        output hi, lo, busy, done, dbg_state
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: 32 radix-2 iterations on magnitudes, a
// sign-fixup cycle, and the architectural HI/LO registers (MTHI/MTLO).
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    mult_div_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         r_state;
    logic [4:0]         r_cnt;
    logic [2*WIDTH-1:0] r_work;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_a_orig;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_done;

    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_is_div;
    logic               w_div0;
    logic [WIDTH:0]     w_madd;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_signed = ~bus.op[0];
    assign w_a_neg  = w_signed & bus.srcA[WIDTH-1];
    assign w_b_neg  = w_signed & bus.srcB[WIDTH-1];
    assign w_a_mag  = w_a_neg ? (~bus.srcA + 1'b1) : bus.srcA;
    assign w_b_mag  = w_b_neg ? (~bus.srcB + 1'b1) : bus.srcB;
    assign w_is_div = r_op[1];
    assign w_div0   = (r_b == '0);

    // Multiply: add the multiplicand into the upper half for each set
    // multiplier bit, then shift right so the low product bits fill the bottom.
    assign w_madd     = {1'b0, r_work[2*WIDTH-1:WIDTH]} + (r_b[r_cnt] ? {1'b0, r_a} : '0);
    assign w_mul_next = {w_madd, r_work[WIDTH-1:1]};

    // Divide: shift the next dividend bit into the remainder and keep the
    // difference only when it does not borrow (remainder < divisor fits 33 bits).
    assign w_trial    = {r_work[2*WIDTH-1:WIDTH], r_a[5'd31 - r_cnt]};
    assign w_diff     = w_trial - {1'b0, r_b};
    assign w_div_next = w_diff[WIDTH] ? {w_trial[WIDTH-1:0], r_work[WIDTH-2:0], 1'b0}
                                      : {w_diff[WIDTH-1:0],  r_work[WIDTH-2:0], 1'b1};

    assign w_prod = r_neg_q ? (~r_work + 1'b1) : r_work;
    assign w_quo  = r_neg_q ? (~r_work[WIDTH-1:0] + 1'b1) : r_work[WIDTH-1:0];
    assign w_rem  = r_neg_r ? (~r_work[2*WIDTH-1:WIDTH] + 1'b1) : r_work[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_work   <= '0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_a_orig <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op     <= bus.op;
                        r_a      <= w_a_mag;
                        r_b      <= w_b_mag;
                        r_a_orig <= bus.srcA;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_work   <= '0;
                        r_cnt    <= '0;
                        r_state  <= S_RUN;
                    end else begin
                        if (bus.we_hi) r_hi <= bus.wdata;
                        if (bus.we_lo) r_lo <= bus.wdata;
                    end
                end
                S_RUN: begin
                    r_work <= w_is_div ? w_div_next : w_mul_next;
                    r_cnt  <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) r_state <= S_FIX;
                end
                S_FIX: begin
                    if (!w_is_div) begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end else if (w_div0) begin
                        // Divide by zero returns all-ones quotient and the raw dividend.
                        r_hi <= r_a_orig;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_done;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized checks of mult_div_unit against an arithmetic
// reference model of MIPS MULT/MULTU/DIV/DIVU and MTHI/MTLO.
module tb_mult_div_unit;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    mult_div_if #(.WIDTH(32)) bus_if ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, q, rm;
        logic [63:0] ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'b00: begin
                q = sa * sb;
                return q;
            end
            2'b01: return ua * ub;
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q  = sa / sb;
                rm = sa % sb;
                return {rm[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // inject: 0 none, 1 start/we_hi pulse mid-run, 2 reset mid-run, 3 we_hi/we_lo with start
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int inject);
        int          busy_cnt;
        bit          got_done;
        bit          hold_ok;
        logic [63:0] r;
        busy_cnt = 0;
        got_done = 1'b0;
        hold_ok  = 1'b1;
        r = ref_result(op, a, b);
        bus_if.start = 1'b1;
        bus_if.op    = op;
        bus_if.srcA  = a;
        bus_if.srcB  = b;
        if (inject == 3) begin
            bus_if.we_hi = 1'b1;
            bus_if.we_lo = 1'b1;
            bus_if.wdata = 32'h5555_5555;
        end
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.we_hi = 1'b0;
        bus_if.we_lo = 1'b0;
        bus_if.op    = 2'($urandom_range(0, 3));
        bus_if.srcA  = $urandom;
        bus_if.srcB  = $urandom;
        for (int i = 1; i <= 60 && !got_done; i++) begin
            if (i > 1) @(negedge clk);
            if (inject == 2 && i == 10) begin
                reset = 1'b1;
                #1;
                check({tag, "_rst_busy"}, 64'(bus_if.busy), 64'd0);
                check({tag, "_rst_done"}, 64'(bus_if.done), 64'd0);
                check({tag, "_rst_hi"}, 64'(bus_if.hi), 64'd0);
                check({tag, "_rst_lo"}, 64'(bus_if.lo), 64'd0);
                exp_hi = 32'd0;
                exp_lo = 32'd0;
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            if (inject == 1 && i == 5) begin
                bus_if.start = 1'b1;
                bus_if.op    = 2'b00;
                bus_if.srcA  = 32'h0000_0123;
                bus_if.srcB  = 32'h0000_0456;
                bus_if.we_hi = 1'b1;
                bus_if.wdata = 32'h0000_1234;
            end
            if (inject == 1 && i == 6) begin
                bus_if.start = 1'b0;
                bus_if.we_hi = 1'b0;
            end
            if (bus_if.done && !bus_if.busy) begin
                got_done = 1'b1;
            end else begin
                if (bus_if.busy) busy_cnt++;
                if (bus_if.done) hold_ok = 1'b0;
                if (bus_if.hi !== exp_hi || bus_if.lo !== exp_lo) hold_ok = 1'b0;
            end
        end
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
        check({tag, "_done_seen"}, 64'(got_done), 64'd1);
        check({tag, "_hold"}, 64'(hold_ok), 64'd1);
        check({tag, "_hi"}, 64'(bus_if.hi), 64'(r[63:32]));
        check({tag, "_lo"}, 64'(bus_if.lo), 64'(r[31:0]));
        exp_hi = r[63:32];
        exp_lo = r[31:0];
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        n_tests = 0;
        n_fail  = 0;
        exp_hi  = 32'd0;
        exp_lo  = 32'd0;
        reset = 1'b1;
        bus_if.start = 1'b0;
        bus_if.op    = 2'b00;
        bus_if.srcA  = 32'd0;
        bus_if.srcB  = 32'd0;
        bus_if.we_hi = 1'b0;
        bus_if.we_lo = 1'b0;
        bus_if.wdata = 32'd0;
        @(negedge clk);
        @(negedge clk);
        check("reset_busy", 64'(bus_if.busy), 64'd0);
        check("reset_done", 64'(bus_if.done), 64'd0);
        check("reset_hi", 64'(bus_if.hi), 64'd0);
        check("reset_lo", 64'(bus_if.lo), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        bus_if.we_hi = 1'b1;
        bus_if.we_lo = 1'b1;
        bus_if.wdata = 32'hCAFE_0001;
        @(negedge clk);
        bus_if.we_hi = 1'b0;
        bus_if.we_lo = 1'b0;
        exp_hi = 32'hCAFE_0001;
        exp_lo = 32'hCAFE_0001;
        check("mthi_mtlo_hi", 64'(bus_if.hi), 64'(exp_hi));
        check("mthi_mtlo_lo", 64'(bus_if.lo), 64'(exp_lo));

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3);
        run_op("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 0);
        run_op("mult_minxmin", 2'b00, 32'h8000_0000, 32'h8000_0000, 0);
        run_op("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("divu_7d0", 2'b11, 32'd7, 32'd0, 0);
        run_op("div_neg_d0", 2'b10, 32'hFFFF_FFF9, 32'd0, 0);
        run_op("divu_100d7", 2'b11, 32'd100, 32'd7, 0);
        run_op("div_7dm2", 2'b10, 32'd7, 32'hFFFF_FFFE, 0);
        run_op("ignore_busy", 2'b11, 32'd1000, 32'd3, 1);

        bus_if.we_lo = 1'b1;
        bus_if.wdata = 32'h0000_ABCD;
        @(negedge clk);
        bus_if.we_lo = 1'b0;
        exp_lo = 32'h0000_ABCD;
        check("mtlo_lo", 64'(bus_if.lo), 64'(exp_lo));
        check("mtlo_hi_kept", 64'(bus_if.hi), 64'(exp_hi));

        for (int k = 0; k < 10; k++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 15));
            run_op($sformatf("rand%0d_op%0d", k, rop), rop, ra, rb, 0);
        end

        run_op("reset_mid_div", 2'b10, 32'h1234_5678, 32'd9, 2);
        run_op("multu_3x5", 2'b01, 32'd3, 32'd5, 0);
        @(negedge clk);
        check("done_single_pulse", 64'(bus_if.done), 64'd0);
        check("idle_busy_low", 64'(bus_if.busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
